// File: rtl/ptr_rsp_gen.sv
// Pointer-sequence responder: buffers incoming pointers and answers each one with its successor from a next-pointer table.
// Optional feature macro: PTR_RSP_ORDER_CHK_EN (list-ordering checker driving err).
module ptr_rsp_gen #(
  parameter int PTR_W  = 8,
  parameter int TBL_AW = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PTR_W-1:0]           in_ptr,
  input  logic                       in_ptr_vld,
  input  logic                       tbl_we,
  input  logic [TBL_AW-1:0]          tbl_addr,
  input  logic [PTR_W-1:0]           tbl_wdata,
  output logic [PTR_W-1:0]           rsp_ptr,
  output logic [PTR_W-1:0]           rsp_next,
  output logic                       rsp_last,
  output logic                       rsp_oor,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       ovf,
  output logic                       err
);
  // rsp_* follows valid/ready: a response transfers on a rising edge where
  // rsp_vld and rsp_rdy are both 1; while rsp_vld=1 and rsp_rdy=0 it is held.
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TN = 1 << TBL_AW;
  localparam logic [PTR_W-1:0] NIL = '1;

  logic [PTR_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] tbl [TN];
  logic [IW-1:0]    rd_idx, wr_idx;
  logic [CW-1:0]    cnt;
  logic             full, empty, pop, push;
  logic [PTR_W-1:0] head, lk_next;
  logic             head_oor;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign pop      = !empty && (!rsp_vld || rsp_rdy);
  assign push     = in_ptr_vld && (!full || pop);
  assign head     = fifo_mem[rd_idx];
  assign head_oor = |head[PTR_W-1:TBL_AW];
  // Table is read before this edge's write lands, so a same-cycle write returns the old entry.
  assign lk_next  = head_oor ? NIL : tbl[head[TBL_AW-1:0]];
  assign fifo_cnt = cnt;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= in_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (in_ptr_vld && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TN; i++) tbl[i] <= NIL;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_vld  <= 1'b0;
      rsp_ptr  <= '0;
      rsp_next <= '0;
      rsp_last <= 1'b0;
      rsp_oor  <= 1'b0;
    end else if (pop) begin
      rsp_vld  <= 1'b1;
      rsp_ptr  <= head;
      rsp_next <= lk_next;
      rsp_last <= (lk_next == NIL);
      rsp_oor  <= head_oor;
    end else if (rsp_vld && rsp_rdy) begin
      rsp_vld  <= 1'b0;
    end
  end

`ifdef PTR_RSP_ORDER_CHK_EN
  // prev_open: an accepted response with rsp_last=0 is waiting for its successor.
  logic             prev_open;
  logic [PTR_W-1:0] prev_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_open <= 1'b0;
      prev_next <= '0;
      err       <= 1'b0;
    end else if (rsp_vld && rsp_rdy) begin
      if (prev_open && (rsp_ptr != prev_next)) err <= 1'b1;
      prev_open <= !rsp_last;
      prev_next <= rsp_next;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_rsp_gen.sv
// Self-checking bench for ptr_rsp_gen: scoreboard of expected responses plus direct status checks.
module tb_ptr_rsp_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_ptr = '0;
  logic       in_ptr_vld = 1'b0;
  logic       tbl_we = 1'b0;
  logic [3:0] tbl_addr = '0;
  logic [7:0] tbl_wdata = '0;
  logic [7:0] rsp_ptr, rsp_next;
  logic       rsp_last, rsp_oor, rsp_vld;
  logic       rsp_rdy = 1'b1;
  logic [2:0] fifo_cnt;
  logic       ovf, err;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  mtbl [16];

  ptr_rsp_gen #(.PTR_W(8), .TBL_AW(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_ptr(in_ptr), .in_ptr_vld(in_ptr_vld),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .rsp_ptr(rsp_ptr), .rsp_next(rsp_next), .rsp_last(rsp_last),
    .rsp_oor(rsp_oor), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model_rsp(input logic [7:0] p);
    logic [7:0] n;
    if (p[7:4] != 4'd0) return {p, 8'hFF, 1'b1, 1'b1};
    n = mtbl[p[3:0]];
    return {p, n, (n == 8'hFF), 1'b0};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    in_ptr_vld = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) mtbl[i] = 8'hFF;
    rst = 1'b1;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [7:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
    mtbl[a] = d;
  endtask

  // Drives one pointer for one cycle; expectation is taken from the model table now.
  task automatic push_ptr(input logic [7:0] p, input bit expect_kept);
    in_ptr = p; in_ptr_vld = 1'b1;
    if (expect_kept) exp_q.push_back(model_rsp(p));
    tick();
    in_ptr_vld = 1'b0;
  endtask

  // Scoreboard: every accepted response is compared against the queue head.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {24'd0, rsp_ptr}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("rsp_ptr",  {24'd0, rsp_ptr},  {24'd0, e[17:10]});
        check("rsp_next", {24'd0, rsp_next}, {24'd0, e[9:2]});
        check("rsp_last", {31'd0, rsp_last}, {31'd0, e[1]});
        check("rsp_oor",  {31'd0, rsp_oor},  {31'd0, e[0]});
      end
    end
  end

  initial begin
    // Reset state
    rsp_rdy = 1'b1;
    do_reset();
    rst = 1'b0;
    tick();
    check("rst_vld",  {31'd0, rsp_vld}, 0);
    check("rst_ptr",  {24'd0, rsp_ptr}, 0);
    check("rst_next", {24'd0, rsp_next}, 0);
    check("rst_last", {31'd0, rsp_last}, 0);
    check("rst_oor",  {31'd0, rsp_oor}, 0);
    check("rst_cnt",  {29'd0, fifo_cnt}, 0);
    check("rst_ovf",  {31'd0, ovf}, 0);
    check("rst_err",  {31'd0, err}, 0);
    rst = 1'b1;
    tick();

    // Two-cycle latency on a NIL entry
    push_ptr(8'h03, 1);
    check("lat_vld_n", {31'd0, rsp_vld}, 0);
    check("lat_cnt_n", {29'd0, fifo_cnt}, 1);
    tick();
    check("lat_vld_n1", {31'd0, rsp_vld}, 1);
    tick();
    check("lat_drop", {31'd0, rsp_vld}, 0);

    // Linked list 0->1->3->2->NIL at full throughput
    tbl_write(4'd0, 8'h01);
    tbl_write(4'd1, 8'h03);
    tbl_write(4'd3, 8'h02);
    tbl_write(4'd2, 8'hFF);
    push_ptr(8'h00, 1);
    push_ptr(8'h01, 1);
    check("thr_vld1", {31'd0, rsp_vld}, 1);
    push_ptr(8'h03, 1);
    check("thr_vld2", {31'd0, rsp_vld}, 1);
    push_ptr(8'h02, 1);
    check("thr_vld3", {31'd0, rsp_vld}, 1);
    tick();
    check("thr_vld4", {31'd0, rsp_vld}, 1);
    tick();
    check("thr_idle", {31'd0, rsp_vld}, 0);
    check("list_err", {31'd0, err}, 0);

    // Overflow: one held, four buffered, sixth dropped
    rsp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) push_ptr(8'(4 + i), i < 5);
    check("ovf_cnt",  {29'd0, fifo_cnt}, 4);
    check("ovf_flag", {31'd0, ovf}, 1);
    check("ovf_held", {24'd0, rsp_ptr}, 4);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("ovf_drain_cnt", {29'd0, fifo_cnt}, 0);
    check("ovf_drain_vld", {31'd0, rsp_vld}, 0);
    check("ovf_sticky", {31'd0, ovf}, 1);
    check("ovf_sb_empty", exp_q.size(), 0);
    do_reset();
    tick();

    // Full FIFO with simultaneous push and pop
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_ptr(8'(10 + i), 1);
    check("full_cnt", {29'd0, fifo_cnt}, 4);
    check("full_ovf0", {31'd0, ovf}, 0);
    rsp_rdy = 1'b1;
    push_ptr(8'h0F, 1);
    check("full_pp_cnt", {29'd0, fifo_cnt}, 4);
    check("full_pp_ovf", {31'd0, ovf}, 0);
    for (int i = 0; i < 6; i++) tick();
    check("full_sb_empty", exp_q.size(), 0);

    // Out-of-range pointer, then same-cycle table write against lookup
    push_ptr(8'h25, 1);
    tick();
    check("oor_flag", {31'd0, rsp_oor}, 1);
    check("oor_next", {24'd0, rsp_next}, 8'hFF);
    tbl_write(4'd5, 8'h07);
    push_ptr(8'h05, 1);
    tbl_we = 1'b1; tbl_addr = 4'd5; tbl_wdata = 8'h09;
    tick();
    tbl_we = 1'b0;
    mtbl[5] = 8'h09;
    check("wr_old_next", {24'd0, rsp_next}, 8'h07);
    push_ptr(8'h07, 1);
    push_ptr(8'h05, 1);
    push_ptr(8'h09, 1);
    for (int i = 0; i < 3; i++) tick();
    check("wr_sb_empty", exp_q.size(), 0);

    // Ordering checker: 0 -> 1 expected but 2 follows
    do_reset();
    tick();
    tbl_write(4'd0, 8'h01);
    push_ptr(8'h00, 1);
    push_ptr(8'h02, 1);
    for (int i = 0; i < 3; i++) tick();
`ifdef PTR_RSP_ORDER_CHK_EN
    check("order_err", {31'd0, err}, 1);
`else
    check("order_err", {31'd0, err}, 0);
`endif

    // Reset mid-stream discards buffered and held responses
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push_ptr(8'(i), 1);
    rsp_rdy = 1'b1;
    do_reset();
    check("mid_rst_vld", {31'd0, rsp_vld}, 0);
    check("mid_rst_err", {31'd0, err}, 0);
    check("mid_rst_cnt", {29'd0, fifo_cnt}, 0);
    tick();
    tick();
    check("mid_rst_idle", {31'd0, rsp_vld}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
